array_allocator: RTL and testbench

- Hardware allocator and size tracker for the interpreter's heap arrays.
- Hands out array ids from a fresh-id counter or a freed-array stack, and reclaims ids on free.
- Tracks each array's length (max index written + 1) and the high-water mark of live allocations.
- Sits beside the instruction sequencer; the sequencer issues alloc/free requests and size updates instead of manipulating arraySizes and freedArrays inline.

---
 rtl/zero_pkg.sv | 18 +
 rtl/freed_array_stack.sv | 43 ++++
 rtl/array_allocator.sv | 179 +++++++++++++++++
 tb/tb_array_allocator.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zero_pkg.sv
// Shared types and default sizing for the heap-array allocator.
package zero_pkg;

    localparam int unsigned DefaultMemoryElementWidth = 12;
    localparam int unsigned DefaultNArrays = 2000;

    typedef enum logic {
        ALLOC = 1'b0,
        FREE  = 1'b1
    } alloc_op_t;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } alloc_state_t;

endpackage

// File: rtl/freed_array_stack.sv
// LIFO of reclaimed array ids; only the pointer is reset, the storage is plain RAM.
module freed_array_stack #(
    parameter int unsigned Depth = 2000,
    parameter int unsigned Width = 12
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [Width-1:0] push_data,
    output logic [Width-1:0] top_data,
    output logic             empty
);

    localparam int unsigned PtrW = $clog2(Depth + 1);
    localparam int unsigned IdxW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [PtrW-1:0]  ptr;
    logic [PtrW-1:0]  ptr_m1;
    logic [Width-1:0] mem [Depth];

    assign ptr_m1   = ptr - PtrW'(1);
    assign empty    = (ptr == '0);
    assign top_data = mem[ptr_m1[IdxW-1:0]];

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr <= '0;
        end else if (push && !pop) begin
            ptr <= ptr + PtrW'(1);
        end else if (pop && !push) begin
            ptr <= ptr_m1;
        end
    end

    // Pushes are bounded by the number of live ids, so the slot at ptr always exists.
    always_ff @(posedge clock) begin
        if (push && !pop) begin
            mem[ptr[IdxW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/array_allocator.sv
// Heap-array id allocator: fresh/LIFO-reuse ids, per-array length tracking, live-count stats.
module array_allocator
    import zero_pkg::*;
#(
    parameter int unsigned MemoryElementWidth = DefaultMemoryElementWidth,
    parameter int unsigned NArrays            = DefaultNArrays
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          reqValid,
    input  logic                          reqOp,
    input  logic [MemoryElementWidth-1:0] reqArray,
    output logic                          reqReady,
    output logic                          rspValid,
    output logic [MemoryElementWidth-1:0] rspArray,
    output logic                          rspError,
    input  logic                          sizeWrValid,
    input  logic [MemoryElementWidth-1:0] sizeWrArray,
    input  logic [MemoryElementWidth-1:0] sizeWrIndex,
    input  logic [MemoryElementWidth-1:0] sizeRdArray,
    output logic [MemoryElementWidth-1:0] sizeRdData,
    output logic [MemoryElementWidth:0]   inUse,
    output logic [MemoryElementWidth:0]   allocs
);

    localparam int unsigned W        = MemoryElementWidth;
    localparam int unsigned IdxW     = (NArrays > 1) ? $clog2(NArrays) : 1;
    localparam logic [W:0]  NArraysW = (W + 1)'(NArrays);

    alloc_state_t   state;
    alloc_op_t      op_q;
    logic [W-1:0]   arr_q;
    logic [W:0]     next_fresh;
    logic [NArrays-1:0] live;
    logic [W-1:0]   sizes [NArrays];

    logic           stk_push;
    logic           stk_pop;
    logic [W-1:0]   stk_top;
    logic           stk_empty;

    logic           exec_ok;
    logic [W-1:0]   exec_id;
    logic [IdxW-1:0] exec_idx;
    logic           fresh_take;
    logic [W:0]     in_use_inc;

    logic [IdxW-1:0] wr_idx;
    logic [IdxW-1:0] rd_idx;
    logic            wr_en;
    logic [W:0]      wr_inc;
    logic [W-1:0]    wr_sat;
    logic [W-1:0]    wr_cur;
    logic            rd_ok;

    freed_array_stack #(
        .Depth (NArrays),
        .Width (W)
    ) u_freed_array_stack (
        .clock     (clock),
        .reset     (reset),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (arr_q),
        .top_data  (stk_top),
        .empty     (stk_empty)
    );

    always_comb begin
        exec_ok    = 1'b0;
        exec_id    = '0;
        stk_push   = 1'b0;
        stk_pop    = 1'b0;
        fresh_take = 1'b0;
        if (state == EXEC) begin
            if (op_q == ALLOC) begin
                if (!stk_empty) begin
                    exec_ok = 1'b1;
                    exec_id = stk_top;
                    stk_pop = 1'b1;
                end else if (next_fresh < NArraysW) begin
                    exec_ok    = 1'b1;
                    exec_id    = next_fresh[W-1:0];
                    fresh_take = 1'b1;
                end
            end else if (({1'b0, arr_q} < next_fresh) && live[arr_q[IdxW-1:0]]) begin
                exec_ok  = 1'b1;
                exec_id  = arr_q;
                stk_push = 1'b1;
            end
        end
    end

    assign exec_idx   = exec_id[IdxW-1:0];
    assign in_use_inc = inUse + (W + 1)'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            reqReady   <= 1'b1;
            rspValid   <= 1'b0;
            rspArray   <= '0;
            rspError   <= 1'b0;
            inUse      <= '0;
            allocs     <= '0;
            next_fresh <= '0;
            live       <= '0;
            op_q       <= ALLOC;
            arr_q      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (reqValid) begin
                        op_q     <= alloc_op_t'(reqOp);
                        arr_q    <= reqArray;
                        reqReady <= 1'b0;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    state    <= RESP;
                    rspValid <= 1'b1;
                    rspError <= !exec_ok;
                    rspArray <= (op_q == FREE) ? arr_q : exec_id;
                    if (exec_ok && op_q == ALLOC) begin
                        live[exec_idx] <= 1'b1;
                        inUse          <= in_use_inc;
                        if (in_use_inc > allocs) begin
                            allocs <= in_use_inc;
                        end
                        if (fresh_take) begin
                            next_fresh <= next_fresh + (W + 1)'(1);
                        end
                    end else if (exec_ok) begin
                        live[exec_idx] <= 1'b0;
                        inUse          <= inUse - (W + 1)'(1);
                    end
                end
                RESP: begin
                    rspValid <= 1'b0;
                    reqReady <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // A size update that collides with an alloc/free of the same id loses to it.
    assign wr_idx = sizeWrArray[IdxW-1:0];
    assign wr_cur = sizes[wr_idx];
    assign wr_inc = {1'b0, sizeWrIndex} + (W + 1)'(1);
    assign wr_sat = wr_inc[W] ? '1 : wr_inc[W-1:0];
    assign wr_en  = sizeWrValid && ({1'b0, sizeWrArray} < NArraysW) && live[wr_idx]
                    && !(exec_ok && (exec_id == sizeWrArray));

    assign rd_idx = sizeRdArray[IdxW-1:0];
    assign rd_ok  = ({1'b0, sizeRdArray} < NArraysW) && live[rd_idx];

    always_ff @(posedge clock) begin
        if (exec_ok && op_q == ALLOC) begin
            sizes[exec_idx] <= '0;
        end
        if (wr_en && (wr_sat > wr_cur)) begin
            sizes[wr_idx] <= wr_sat;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sizeRdData <= '0;
        end else begin
            sizeRdData <= rd_ok ? sizes[rd_idx] : '0;
        end
    end

endmodule

// File: tb/tb_array_allocator.sv
// Bench for array_allocator: directed literal checks plus a randomized run against a queue model.
module tb_array_allocator;

    localparam int W    = 12;
    localparam int N    = 4;
    localparam int SMAX = (1 << W) - 1;

    logic         clock = 1'b0;
    logic         reset;
    logic         reqValid;
    logic         reqOp;
    logic [W-1:0] reqArray;
    logic         reqReady;
    logic         rspValid;
    logic [W-1:0] rspArray;
    logic         rspError;
    logic         sizeWrValid;
    logic [W-1:0] sizeWrArray;
    logic [W-1:0] sizeWrIndex;
    logic [W-1:0] sizeRdArray;
    logic [W-1:0] sizeRdData;
    logic [W:0]   inUse;
    logic [W:0]   allocs;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    array_allocator #(
        .MemoryElementWidth (W),
        .NArrays            (N)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .reqValid    (reqValid),
        .reqOp       (reqOp),
        .reqArray    (reqArray),
        .reqReady    (reqReady),
        .rspValid    (rspValid),
        .rspArray    (rspArray),
        .rspError    (rspError),
        .sizeWrValid (sizeWrValid),
        .sizeWrArray (sizeWrArray),
        .sizeWrIndex (sizeWrIndex),
        .sizeRdArray (sizeRdArray),
        .sizeRdData  (sizeRdData),
        .inUse       (inUse),
        .allocs      (allocs)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: request phase 0=idle, 1=executing, 2=responding.
    int  m_phase;
    int  m_op;
    int  m_arr;
    int  m_freed[$];
    int  m_next;
    bit  m_live[N];
    int  m_size[N];
    int  m_inuse;
    int  m_allocs;
    bit  m_ready;
    bit  m_rvalid;
    bit  m_rerr;
    bit  m_rerr_alloc;
    int  m_rarr;
    int  m_rd;

    always @(posedge clock) begin : model
        int rd_next;
        int id;
        int v;
        int wa;
        int ra;
        bit ok;
        if (reset) begin
            m_phase  = 0;
            m_freed.delete();
            m_next   = 0;
            m_inuse  = 0;
            m_allocs = 0;
            m_ready  = 1'b1;
            m_rvalid = 1'b0;
            m_rd     = 0;
            foreach (m_live[i]) m_live[i] = 1'b0;
        end else begin
            ra      = int'(sizeRdArray);
            wa      = int'(sizeWrArray);
            rd_next = (ra < N && m_live[ra]) ? m_size[ra] : 0;
            ok      = 1'b0;
            id      = -1;
            if (m_phase == 1) begin
                if (m_op == 0) begin
                    if (m_freed.size() > 0) begin
                        ok = 1'b1;
                        id = m_freed[$];
                    end else if (m_next < N) begin
                        ok = 1'b1;
                        id = m_next;
                    end
                end else if (m_arr < m_next && m_live[m_arr]) begin
                    ok = 1'b1;
                    id = m_arr;
                end
            end
            if (sizeWrValid && wa < N && m_live[wa] && !(ok && id == wa)) begin
                v = int'(sizeWrIndex) + 1;
                if (v > SMAX) v = SMAX;
                if (v > m_size[wa]) m_size[wa] = v;
            end
            m_rvalid = (m_phase == 1);
            if (m_phase == 1) begin
                m_rerr       = !ok;
                m_rerr_alloc = (m_op == 0) && !ok;
                m_rarr       = (m_op == 1) ? m_arr : id;
                if (ok && m_op == 0) begin
                    if (m_freed.size() > 0) void'(m_freed.pop_back());
                    else m_next++;
                    m_live[id] = 1'b1;
                    m_size[id] = 0;
                    m_inuse++;
                    if (m_inuse > m_allocs) m_allocs = m_inuse;
                end else if (ok) begin
                    m_freed.push_back(id);
                    m_live[id] = 1'b0;
                    m_inuse--;
                end
                m_phase = 2;
            end else if (m_phase == 2) begin
                m_phase = 0;
            end else if (reqValid) begin
                m_op    = int'(reqOp);
                m_arr   = int'(reqArray);
                m_phase = 1;
            end
            m_ready = (m_phase == 0);
            m_rd    = rd_next;
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("cmp_reqReady", int'(reqReady), int'(m_ready));
            check("cmp_rspValid", int'(rspValid), int'(m_rvalid));
            check("cmp_sizeRdData", int'(sizeRdData), m_rd);
            check("cmp_inUse", int'(inUse), m_inuse);
            check("cmp_allocs", int'(allocs), m_allocs);
            if (m_rvalid) begin
                check("cmp_rspError", int'(rspError), int'(m_rerr));
                if (!m_rerr_alloc) check("cmp_rspArray", int'(rspArray), m_rarr);
            end
        end
    end

    // Entered and left just after a negedge; optionally drives a size write during EXEC.
    task automatic do_req(input int op, input int arr, input bit coll, input int carr,
                          input int cidx, output int rid, output int rerr);
        int n;
        int lat;
        n = 0;
        while (!reqReady && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("ready_wait", int'(n < 20), 1);
        reqValid = 1'b1;
        reqOp    = op[0];
        reqArray = W'(arr);
        @(negedge clock);
        reqValid = 1'b0;
        if (coll) begin
            sizeWrValid = 1'b1;
            sizeWrArray = W'(carr);
            sizeWrIndex = W'(cidx);
        end
        lat = 1;
        while (!rspValid && lat < 10) begin
            @(negedge clock);
            sizeWrValid = 1'b0;
            lat++;
        end
        sizeWrValid = 1'b0;
        check("rsp_latency", lat, 2);
        rid  = int'(rspArray);
        rerr = int'(rspError);
    endtask

    task automatic alloc_expect(input int exp_id, input int exp_err);
        int rid;
        int rerr;
        do_req(0, 0, 1'b0, 0, 0, rid, rerr);
        check("alloc_err", rerr, exp_err);
        if (exp_err == 0) check("alloc_id", rid, exp_id);
    endtask

    task automatic free_expect(input int arr, input int exp_err);
        int rid;
        int rerr;
        do_req(1, arr, 1'b0, 0, 0, rid, rerr);
        check("free_err", rerr, exp_err);
        check("free_echo", rid, arr);
    endtask

    task automatic wr_size(input int a, input int idx);
        sizeWrValid = 1'b1;
        sizeWrArray = W'(a);
        sizeWrIndex = W'(idx);
        @(negedge clock);
        sizeWrValid = 1'b0;
    endtask

    task automatic rd_expect(input int a, input int exp);
        sizeRdArray = W'(a);
        @(negedge clock);
        check("size_read", int'(sizeRdData), exp);
    endtask

    task automatic cnt_expect(input int exp_inuse, input int exp_allocs);
        check("inUse", int'(inUse), exp_inuse);
        check("allocs", int'(allocs), exp_allocs);
    endtask

    initial begin
        int rid;
        int rerr;
        reset       = 1'b1;
        reqValid    = 1'b0;
        reqOp       = 1'b0;
        reqArray    = '0;
        sizeWrValid = 1'b0;
        sizeWrArray = '0;
        sizeWrIndex = '0;
        sizeRdArray = '0;
        @(negedge clock);
        chk_en = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("rst_reqReady", int'(reqReady), 1);
        check("rst_rspValid", int'(rspValid), 0);
        check("rst_sizeRdData", int'(sizeRdData), 0);
        cnt_expect(0, 0);

        alloc_expect(0, 0);
        alloc_expect(1, 0);
        alloc_expect(2, 0);
        cnt_expect(3, 3);

        free_expect(1, 0);
        free_expect(0, 0);
        alloc_expect(0, 0);
        alloc_expect(1, 0);
        cnt_expect(3, 3);

        wr_size(2, 4);
        rd_expect(2, 5);
        wr_size(2, 2);
        rd_expect(2, 5);
        wr_size(2, 9);
        rd_expect(2, 10);
        free_expect(2, 0);
        rd_expect(2, 0);
        alloc_expect(2, 0);
        rd_expect(2, 0);

        free_expect(7, 1);
        cnt_expect(3, 3);
        free_expect(0, 0);
        free_expect(0, 1);
        cnt_expect(2, 3);
        alloc_expect(0, 0);
        alloc_expect(3, 0);
        cnt_expect(4, 4);
        alloc_expect(0, 1);
        cnt_expect(4, 4);

        wr_size(3, SMAX);
        rd_expect(3, SMAX);
        wr_size(0, SMAX - 1);
        rd_expect(0, SMAX);

        free_expect(3, 0);
        do_req(0, 0, 1'b1, 3, 7, rid, rerr);
        check("coll_alloc_id", rid, 3);
        rd_expect(3, 0);
        do_req(1, 0, 1'b1, 0, 50, rid, rerr);
        check("coll_free_err", rerr, 0);
        rd_expect(0, 0);

        // Reset lands while the alloc is in EXEC; its response must never appear.
        reqValid = 1'b1;
        reqOp    = 1'b0;
        @(negedge clock);
        reqValid = 1'b0;
        reset    = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("rst_no_rsp", int'(rspValid), 0);
            @(negedge clock);
        end
        alloc_expect(0, 0);
        cnt_expect(1, 1);

        for (int c = 0; c < 3000; c++) begin
            reset       = ($urandom_range(0, 199) == 0);
            reqValid    = $urandom_range(0, 1) == 1;
            reqOp       = $urandom_range(0, 2) == 0;
            reqArray    = W'($urandom_range(0, 7));
            sizeWrValid = $urandom_range(0, 1) == 1;
            sizeWrArray = W'($urandom_range(0, 5));
            sizeWrIndex = ($urandom_range(0, 7) == 0) ? W'(SMAX - int'($urandom_range(0, 1)))
                                                       : W'($urandom_range(0, 40));
            sizeRdArray = W'($urandom_range(0, 5));
            @(negedge clock);
        end
        reset       = 1'b0;
        reqValid    = 1'b0;
        sizeWrValid = 1'b0;
        repeat (4) @(negedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
